dkong_pal_loader: RTL and testbench

- Sequences writes of the 512-byte colour-palette image (256 bytes for PROM 2E, 256 bytes for PROM 2F) from the ROM-download byte stream into the palette RAM pair.
- Drives the palette block's config port: CNF_A, CNF_D, CNF_EN, WE2 and WE3.
- Arbitrates the shared palette address bus against the video pixel path. It takes the bus only while video is blanked or while a download is active.
- Sits between the download interface and the colour-palette block, in the CLK_12M domain.

---
 rtl/dkong_pkg.sv | 36 +++
 rtl/pal_byte_fifo.sv | 62 ++++++
 rtl/dkong_pal_loader.sv | 142 ++++++++++++++
 tb/tb_dkong_pal_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dkong_pkg.sv
// rtl/dkong_pkg.sv - shared constants and types for the palette loader
package dkong_pkg;

  // Total palette image size: 256 bytes for PROM 2E followed by 256 for 2F
  localparam int PAL_BYTES = 512;

  // Offset bits needed to address the full image
  localparam int OFFSET_W = 9;

  // One buffered byte: {offset[8:0], data[7:0]}
  localparam int ENTRY_W = OFFSET_W + 8;

  // Write sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } pal_state_t;

  // Split a buffered entry into the bank select bit
  function automatic logic entry_bank(input logic [ENTRY_W-1:0] e);
    return e[ENTRY_W-1];
  endfunction

  // Split a buffered entry into the in-bank RAM address
  function automatic logic [7:0] entry_addr(input logic [ENTRY_W-1:0] e);
    return e[ENTRY_W-2:8];
  endfunction

  // Split a buffered entry into the data byte
  function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
    return e[7:0];
  endfunction

endpackage

// File: rtl/pal_byte_fifo.sv
// rtl/pal_byte_fifo.sv - generic synchronous FIFO with level output
module pal_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is refused even if a pop happens the same cycle,
  // so the caller can flag the byte as dropped from the full flag alone.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care while the entry is unoccupied
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dkong_pal_loader.sv
// rtl/dkong_pal_loader.sv - streams downloaded palette bytes into the 2E/2F RAMs
module dkong_pal_loader
  import dkong_pkg::*;
#(
  parameter logic [15:0] PAL_BASE   = 16'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK_12M,
  input  logic        I_RST,
  input  logic        I_DL_ACTIVE,
  input  logic        I_DL_WR,
  input  logic [15:0] I_DL_ADDR,
  input  logic [7:0]  I_DL_D,
  output logic        O_DL_WAIT,
  input  logic        I_CMPBLKn,
  output logic [7:0]  O_CNF_A,
  output logic [7:0]  O_CNF_D,
  output logic        O_CNF_EN,
  output logic        O_WE2,
  output logic        O_WE3,
  output logic        O_PAL_READY,
  output logic        O_OVF
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]        offset;
  logic               in_range;
  logic               accept;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic               grant;

  pal_state_t         state;
  logic               bank;
  logic [9:0]         byte_cnt;

  // Unsigned wrap makes addresses below PAL_BASE land far out of range
  assign offset   = I_DL_ADDR - PAL_BASE;
  assign in_range = (offset < 16'(PAL_BYTES));
  assign accept   = I_DL_WR & in_range;
  assign fifo_push = accept;

  // The palette bus may be borrowed during blanking or while downloading
  assign grant    = I_DL_ACTIVE | ~I_CMPBLKn;
  assign fifo_pop = (state == IDLE) & ~fifo_empty & grant;

  // Throttle one entry early so a strobe already in flight still fits
  assign O_DL_WAIT = (fifo_level >= LVL_W'(FIFO_DEPTH - 1));

  pal_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (CLK_12M),
    .rst       (I_RST),
    .push      (fifo_push),
    .push_data ({offset[OFFSET_W-1:0], I_DL_D}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Sticky record that an in-range byte was lost to a full buffer
  always_ff @(posedge CLK_12M) begin
    if (I_RST) begin
      O_OVF <= 1'b0;
    end else if (accept && fifo_full) begin
      O_OVF <= 1'b1;
    end
  end

  // Write sequencer: address/data setup, single-cycle strobe, hold, then count
  always_ff @(posedge CLK_12M) begin
    if (I_RST) begin
      state       <= IDLE;
      bank        <= 1'b0;
      O_CNF_A     <= 8'h00;
      O_CNF_D     <= 8'h00;
      O_CNF_EN    <= 1'b0;
      O_WE2       <= 1'b0;
      O_WE3       <= 1'b0;
      byte_cnt    <= 10'd0;
      O_PAL_READY <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          O_WE2 <= 1'b0;
          O_WE3 <= 1'b0;
          if (fifo_pop) begin
            bank     <= entry_bank(fifo_head);
            O_CNF_A  <= entry_addr(fifo_head);
            O_CNF_D  <= entry_data(fifo_head);
            O_CNF_EN <= 1'b1;
            state    <= SETUP;
          end else begin
            O_CNF_EN <= 1'b0;
          end
        end
        SETUP: begin
          // Once started the byte always completes, even if blanking ends
          O_CNF_EN <= 1'b1;
          O_WE2    <= ~bank;
          O_WE3    <= bank;
          state    <= WRITE;
        end
        WRITE: begin
          O_CNF_EN <= 1'b1;
          O_WE2    <= 1'b0;
          O_WE3    <= 1'b0;
          state    <= HOLD;
        end
        HOLD: begin
          O_CNF_EN <= 1'b0;
          O_WE2    <= 1'b0;
          O_WE3    <= 1'b0;
          if (byte_cnt != 10'(PAL_BYTES)) begin
            byte_cnt <= byte_cnt + 10'd1;
          end
          if (byte_cnt == 10'(PAL_BYTES - 1)) begin
            O_PAL_READY <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          O_CNF_EN <= 1'b0;
          O_WE2    <= 1'b0;
          O_WE3    <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dkong_pal_loader.sv
// tb/tb_dkong_pal_loader.sv - self-checking bench for dkong_pal_loader
module tb_dkong_pal_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl_active;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_d;
  logic        dl_wait;
  logic        cmpblk_n;
  logic [7:0]  cnf_a;
  logic [7:0]  cnf_d;
  logic        cnf_en;
  logic        we2;
  logic        we3;
  logic        pal_ready;
  logic        ovf;

  int passed = 0;
  int total  = 0;
  int both_we = 0;

  // Every write pulse seen: {bank, addr, data}
  logic [16:0] wq[$];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  d;
    int          exp_en;
    int          exp_we2;
    int          exp_we3;
    logic [7:0]  exp_a;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  dkong_pal_loader #(
    .PAL_BASE   (16'h0000),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK_12M     (clk),
    .I_RST       (rst),
    .I_DL_ACTIVE (dl_active),
    .I_DL_WR     (dl_wr),
    .I_DL_ADDR   (dl_addr),
    .I_DL_D      (dl_d),
    .O_DL_WAIT   (dl_wait),
    .I_CMPBLKn   (cmpblk_n),
    .O_CNF_A     (cnf_a),
    .O_CNF_D     (cnf_d),
    .O_CNF_EN    (cnf_en),
    .O_WE2       (we2),
    .O_WE3       (we3),
    .O_PAL_READY (pal_ready),
    .O_OVF       (ovf)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one cycle and sample outputs 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (we2 || we3) wq.push_back({we3, cnf_a, cnf_d});
    if (we2 && we3) both_we++;
  endtask

  task automatic strobe(input logic [15:0] a, input logic [7:0] d);
    dl_wr = 1'b1; dl_addr = a; dl_d = d;
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    wq.delete();
  endtask

  int en_cnt, we2_cnt, we3_cnt, we_pos, bound, mism, b1;
  logic [7:0] cap_a, cap_d;
  logic [16:0] e;

  initial begin
    rst = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_d = '0; cmpblk_n = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_outputs", int'({dl_wait, cnf_a, cnf_d, cnf_en, we2, we3, pal_ready, ovf}), 0);

    // ---- table of single-byte writes with download active ----
    vecs[0] = '{16'd5,   8'hA7, 3, 1, 0, 8'h05};
    vecs[1] = '{16'd259, 8'h1C, 3, 0, 1, 8'h03};
    vecs[2] = '{16'd0,   8'h00, 3, 1, 0, 8'h00};
    vecs[3] = '{16'd255, 8'h55, 3, 1, 0, 8'hFF};
    vecs[4] = '{16'd256, 8'h80, 3, 0, 1, 8'h00};
    vecs[5] = '{16'd511, 8'hFF, 3, 0, 1, 8'hFF};
    vecs[6] = '{16'd512, 8'h99, 0, 0, 0, 8'h00};
    dl_active = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en_cnt = 0; we2_cnt = 0; we3_cnt = 0; we_pos = 0; cap_a = 0; cap_d = 0;
      strobe(vecs[i].addr, vecs[i].d);
      for (int c = 0; c < 10; c++) begin
        tick();
        if (cnf_en) en_cnt++;
        if (we2 || we3) begin we_pos = en_cnt; cap_a = cnf_a; cap_d = cnf_d; end
        if (we2) we2_cnt++;
        if (we3) we3_cnt++;
      end
      check($sformatf("vec%0d_en_cycles", i), en_cnt, vecs[i].exp_en);
      check($sformatf("vec%0d_we2", i), we2_cnt, vecs[i].exp_we2);
      check($sformatf("vec%0d_we3", i), we3_cnt, vecs[i].exp_we3);
      if (vecs[i].exp_en != 0) begin
        check($sformatf("vec%0d_we_pos", i), we_pos, 2);
        check($sformatf("vec%0d_addr", i), int'(cap_a), int'(vecs[i].exp_a));
        check($sformatf("vec%0d_data", i), int'(cap_d), int'(vecs[i].d));
      end
    end

    // ---- blank arbitration ----
    do_reset();
    dl_active = 1'b0; cmpblk_n = 1'b1;
    strobe(16'd10, 8'h31);
    strobe(16'd11, 8'h32);
    en_cnt = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (cnf_en) en_cnt++; end
    check("blank_no_grant_en", en_cnt, 0);
    cmpblk_n = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    check("blank_two_writes", wq.size(), 2);
    cmpblk_n = 1'b1;

    strobe(16'd20, 8'h41);
    strobe(16'd21, 8'h42);
    wq.delete();
    cmpblk_n = 1'b0;
    tick();
    cmpblk_n = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    check("blank_end_midwrite_count", wq.size(), 1);
    if (wq.size() > 0) check("blank_end_midwrite_data", int'(wq[0]), int'({1'b0, 8'd20, 8'h41}));
    cmpblk_n = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    cmpblk_n = 1'b1;
    check("blank_second_count", wq.size(), 2);
    if (wq.size() > 1) check("blank_second_data", int'(wq[1]), int'({1'b0, 8'd21, 8'h42}));

    // ---- back-pressure and overflow ----
    do_reset();
    strobe(16'd30, 8'h01);
    strobe(16'd31, 8'h02);
    check("wait_after_2", int'(dl_wait), 0);
    strobe(16'd32, 8'h03);
    check("wait_after_3", int'(dl_wait), 1);
    check("ovf_after_3", int'(ovf), 0);
    strobe(16'd33, 8'h04);
    check("ovf_after_4", int'(ovf), 0);
    strobe(16'd34, 8'hEE);
    check("ovf_after_5", int'(ovf), 1);
    cmpblk_n = 1'b0;
    for (int c = 0; c < 24; c++) tick();
    cmpblk_n = 1'b1;
    check("ovf_drain_count", wq.size(), 4);
    mism = 0;
    foreach (wq[k]) if (wq[k][7:0] == 8'hEE) mism++;
    check("ovf_dropped_not_written", mism, 0);
    check("ovf_sticky", int'(ovf), 1);
    check("wait_after_drain", int'(dl_wait), 0);

    // ---- full 512-byte load with out-of-range noise ----
    do_reset();
    dl_active = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bound = 0;
      while (dl_wait && bound < 100) begin tick(); bound++; end
      if (i == 100 || i == 200 || i == 300) begin
        strobe(16'(512 + i), 8'hC3);
        bound = 0;
        while (dl_wait && bound < 100) begin tick(); bound++; end
      end
      strobe(16'(i), 8'(i) ^ 8'h5A);
    end
    bound = 0;
    while (!pal_ready && bound < 3000) begin tick(); bound++; end
    check("full_ready", int'(pal_ready), 1);
    for (int c = 0; c < 4; c++) tick();
    check("full_we_total", wq.size(), 512);
    check("full_ovf", int'(ovf), 0);
    mism = 0; b1 = 0;
    foreach (wq[k]) begin
      e = {1'(k >> 8), 8'(k), 8'(k) ^ 8'h5A};
      if (wq[k] != e) mism++;
      if (wq[k][16]) b1++;
    end
    check("full_content_mismatches", mism, 0);
    check("full_bank2f_count", b1, 256);
    check("both_we_never", both_we, 0);

    // ---- reset during WRITE ----
    strobe(16'd40, 8'h77);
    strobe(16'd41, 8'h78);
    bound = 0;
    while (!(we2 || we3) && bound < 20) begin tick(); bound++; end
    check("rst_reached_write", int'(we2 | we3), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outputs_zero", int'({dl_wait, cnf_a, cnf_d, cnf_en, we2, we3, pal_ready, ovf}), 0);
    wq.delete();
    for (int c = 0; c < 8; c++) tick();
    check("rst_fifo_empty", wq.size(), 0);
    strobe(16'd300, 8'h6B);
    for (int c = 0; c < 8; c++) tick();
    check("rst_after_count", wq.size(), 1);
    if (wq.size() > 0) check("rst_after_data", int'(wq[0]), int'({1'b1, 8'd44, 8'h6B}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
